// File: rtl/seq_match_counter.sv
// seq_match_counter: windowed event counter with valid/ready report, saturating total and threshold alert
module seq_match_counter #(
   parameter int CNT_W   = 8,
   parameter int WIN_LEN = 64,
   parameter int THRESH  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             det_in,
   input  logic             en,
   input  logic             clr,
   output logic [CNT_W-1:0] win_count,
   output logic             win_valid,
   input  logic             win_ready,
   output logic             alert,
   output logic [CNT_W-1:0] total_count,
   output logic             overrun
);
   localparam int TW = $clog2(WIN_LEN);
   localparam logic [CNT_W-1:0] MAX = '1;
   typedef enum logic {IDLE, RUN} state_t;
   state_t state;
   logic det_q, evt, win_end;
   logic [TW-1:0] timer;
   logic [CNT_W-1:0] cnt, cnt_nxt, tot_nxt;
   always_comb begin
      evt = det_in & ~det_q;
      cnt_nxt = (evt && cnt != MAX) ? cnt + CNT_W'(1) : cnt;
      tot_nxt = (evt && total_count != MAX) ? total_count + CNT_W'(1) : total_count;
      win_end = timer == TW'(WIN_LEN - 1);
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         det_q       <= 1'b0;
         timer       <= '0;
         cnt         <= '0;
         win_count   <= '0;
         win_valid   <= 1'b0;
         alert       <= 1'b0;
         total_count <= '0;
         overrun     <= 1'b0;
      end else begin
         det_q <= det_in;
         if (clr) begin
            state       <= IDLE;
            timer       <= '0;
            cnt         <= '0;
            win_count   <= '0;
            win_valid   <= 1'b0;
            alert       <= 1'b0;
            total_count <= '0;
            overrun     <= 1'b0;
         end else begin
            if (win_valid && win_ready)
               win_valid <= 1'b0;
            if (state == IDLE) begin
               alert <= 1'b0;
               if (en) begin
                  state <= RUN;
                  timer <= '0;
                  cnt   <= '0;
               end
            end else if (!en) begin
               state <= IDLE;
               timer <= '0;
               cnt   <= '0;
               alert <= 1'b0;
            end else begin
               total_count <= tot_nxt;
               // equality with THRESH-1 before the step fires once per window, even at saturation
               alert <= evt && cnt == CNT_W'(THRESH - 1);
               if (win_end) begin
                  win_count <= cnt_nxt;
                  win_valid <= 1'b1;
                  overrun   <= overrun | (win_valid & ~win_ready);
                  cnt       <= '0;
                  timer     <= '0;
               end else begin
                  cnt   <= cnt_nxt;
                  timer <= timer + TW'(1);
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_seq_match_counter.sv
// tb_seq_match_counter: scoreboard bench for seq_match_counter (WIN_LEN=16, main and saturating instances)
module tb_seq_match_counter;
   logic clk = 1'b0, rst = 1'b0, det_in = 1'b0, en = 1'b0, clr = 1'b0, win_ready = 1'b0;
   logic [7:0] a_count, a_total;
   logic a_valid, a_alert, a_ov;
   logic [1:0] s_count, s_total;
   logic s_valid, s_alert, s_ov;
   logic sel = 1'b0;
   logic [7:0] c_count, c_total;
   logic c_valid, c_alert, c_ov;
   int n_chk = 0, n_pass = 0;
   int m_win = 0, m_tot = 0, mx = 255, th = 2;
   logic last_det = 1'b0, alert_pend = 1'b0, exp_ov = 1'b0;
   int exp_q[$];

   seq_match_counter #(.CNT_W(8), .WIN_LEN(16), .THRESH(2)) u_a (
      .clk(clk), .rst(rst), .det_in(det_in), .en(en), .clr(clr),
      .win_count(a_count), .win_valid(a_valid), .win_ready(win_ready),
      .alert(a_alert), .total_count(a_total), .overrun(a_ov));

   seq_match_counter #(.CNT_W(2), .WIN_LEN(16), .THRESH(3)) u_s (
      .clk(clk), .rst(rst), .det_in(det_in), .en(en), .clr(clr),
      .win_count(s_count), .win_valid(s_valid), .win_ready(win_ready),
      .alert(s_alert), .total_count(s_total), .overrun(s_ov));

   always #5 clk = ~clk;

   always_comb begin
      c_count = sel ? {6'b0, s_count} : a_count;
      c_total = sel ? {6'b0, s_total} : a_total;
      c_valid = sel ? s_valid : a_valid;
      c_alert = sel ? s_alert : a_alert;
      c_ov    = sel ? s_ov : a_ov;
   end

   task automatic apply_reset();
      en = 1'b0; clr = 1'b0; det_in = 1'b0; win_ready = 1'b0;
      rst = 1'b0;
      #3 rst = 1'b1;
      last_det = 1'b0; alert_pend = 1'b0; exp_ov = 1'b0;
      m_win = 0; m_tot = 0; exp_q.delete();
      @(posedge clk); #1;
   endtask

   // one clock cycle: drive inputs, check registered outputs mid-cycle, advance the model
   task automatic tick(input logic d, input bit run, input logic r);
      logic e;
      int x;
      det_in = d; win_ready = r;
      e = d & ~last_det;
      last_det = d;
      @(negedge clk);
      n_chk++;
      if (c_alert !== alert_pend) $display("FAIL alert got %b exp %b at %0t", c_alert, alert_pend, $time);
      else n_pass++;
      n_chk++;
      if (c_total !== 8'(m_tot)) $display("FAIL total_count got %0d exp %0d at %0t", c_total, m_tot, $time);
      else n_pass++;
      n_chk++;
      if (c_valid !== (exp_q.size() != 0)) $display("FAIL win_valid got %b exp %b at %0t", c_valid, exp_q.size() != 0, $time);
      else n_pass++;
      if (c_valid === 1'b1 && r) begin
         n_chk++;
         if (exp_q.size() == 0) $display("FAIL accept got unexpected window %0d at %0t", c_count, $time);
         else begin
            x = exp_q.pop_front();
            if (c_count !== 8'(x)) $display("FAIL win_count got %0d exp %0d at %0t", c_count, x, $time);
            else n_pass++;
         end
      end
      alert_pend = run && e && m_win == th - 1;
      if (run && e) begin
         if (m_win < mx) m_win++;
         if (m_tot < mx) m_tot++;
      end
      @(posedge clk); #1;
   endtask

   task automatic start_run(input logic r);
      en = 1'b1;
      tick(1'b0, 1'b0, r);
   endtask

   task automatic stop_run(input logic r);
      en = 1'b0;
      tick(1'b0, 1'b0, r);
      m_win = 0;
   endtask

   task automatic drive_window(input logic [15:0] pat, input logic [15:0] rdy);
      for (int i = 0; i < 16; i++) tick(pat[i], 1'b1, rdy[i]);
      if (exp_q.size() != 0) begin
         void'(exp_q.pop_back());
         exp_ov = 1'b1;
      end
      exp_q.push_back(m_win);
      n_chk++;
      if (c_valid !== 1'b1) $display("FAIL window_end_valid got %b exp 1 at %0t", c_valid, $time);
      else n_pass++;
      n_chk++;
      if (c_count !== 8'(m_win)) $display("FAIL window_end_count got %0d exp %0d at %0t", c_count, m_win, $time);
      else n_pass++;
      n_chk++;
      if (c_ov !== exp_ov) $display("FAIL overrun got %b exp %b at %0t", c_ov, exp_ov, $time);
      else n_pass++;
      m_win = 0;
   endtask

   task automatic do_clr();
      en = 1'b0; det_in = 1'b0; last_det = 1'b0; clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      m_tot = 0; m_win = 0; exp_ov = 1'b0; alert_pend = 1'b0; exp_q.delete();
      n_chk++;
      if ({c_valid, c_count, c_total, c_ov, c_alert} !== 19'b0)
         $display("FAIL clr got valid=%b count=%0d total=%0d ov=%b alert=%b exp all 0", c_valid, c_count, c_total, c_ov, c_alert);
      else n_pass++;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #1;
      n_chk++;
      if ({c_valid, c_count, c_total, c_ov, c_alert} !== 19'b0)
         $display("FAIL reset got valid=%b count=%0d total=%0d ov=%b alert=%b exp all 0", c_valid, c_count, c_total, c_ov, c_alert);
      else n_pass++;
      apply_reset();
   endtask

   task automatic test_basic();
      apply_reset();
      start_run(1'b0);
      drive_window(16'h0888, 16'h0000);
      stop_run(1'b0);
      tick(1'b0, 1'b0, 1'b1);
      tick(1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_level();
      apply_reset();
      start_run(1'b0);
      drive_window(16'h141F, 16'h0000);
      stop_run(1'b1);
      tick(1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_saturation();
      sel = 1'b1; mx = 3; th = 3;
      apply_reset();
      start_run(1'b0);
      drive_window(16'h02AA, 16'h0000);
      stop_run(1'b1);
      tick(1'b0, 1'b0, 1'b0);
      sel = 1'b0; mx = 255; th = 2;
   endtask

   task automatic test_overrun();
      apply_reset();
      start_run(1'b0);
      drive_window(16'h0104, 16'h0000);
      drive_window(16'h0010, 16'h0000);
      stop_run(1'b0);
      tick(1'b0, 1'b0, 1'b1);
      tick(1'b0, 1'b0, 1'b0);
      n_chk++;
      if (c_ov !== 1'b1) $display("FAIL overrun_sticky got %b exp 1", c_ov);
      else n_pass++;
      do_clr();
   endtask

   task automatic test_back_to_back();
      apply_reset();
      start_run(1'b1);
      drive_window(16'h8000, 16'hFFFF);
      drive_window(16'h8002, 16'hFFFF);
      drive_window(16'h0010, 16'h8000);
      stop_run(1'b1);
      tick(1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_mid_operation();
      apply_reset();
      start_run(1'b0);
      for (int i = 0; i < 8; i++) tick(i == 2 || i == 5, 1'b1, 1'b0);
      n_chk++;
      if (c_total !== 8'd2) $display("FAIL mid_total got %0d exp 2", c_total);
      else n_pass++;
      #2 rst = 1'b0;
      #1;
      n_chk++;
      if ({c_valid, c_count, c_total, c_ov, c_alert} !== 19'b0)
         $display("FAIL mid_reset got valid=%b count=%0d total=%0d ov=%b alert=%b exp all 0", c_valid, c_count, c_total, c_ov, c_alert);
      else n_pass++;
      apply_reset();
      start_run(1'b0);
      for (int i = 0; i < 8; i++) tick(i == 2 || i == 5, 1'b1, 1'b0);
      stop_run(1'b0);
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1);
      do_clr();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_level();
      test_saturation();
      test_overrun();
      test_back_to_back();
      test_mid_operation();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/seq_match_counter.md
Name: seq_match_counter

Overview:
- Downstream stage of the 1101 Moore sequence detector; consumes its registered `dout` on `det_in`.
- Counts detection events over fixed-length time windows and reports each window count to a consumer over a valid/ready handshake.
- Keeps a saturating running total and raises a one-cycle alert when a window's count reaches a threshold.
- Single clock domain, same clock as the detector.

Parameters:
- CNT_W, 8: width of the window and total counters.
- WIN_LEN, 64: window length in clock cycles; must be ≥ 2.
- THRESH, 4: window count that triggers `alert`; must be ≥ 1 and ≤ 2^CNT_W-1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- det_in  input  1  detector output (`dout`); a high level marks a match.
- en  input  1  counting enable.
- clr  input  1  synchronous clear of counters and flags.
- win_count  output  CNT_W  count for the last completed window.
- win_valid  output  1  `win_count` holds unconsumed data.
- win_ready  input  1  consumer accepts `win_count`.
- alert  output  1  one-cycle pulse: the current window count has just reached THRESH.
- total_count  output  CNT_W  saturating count of all events since reset/clr.
- overrun  output  1  sticky: a completed window overwrote unconsumed data.

Behaviour:
- Reset (rst=0, asynchronous): FSM=IDLE; all outputs and internal registers are 0, including `det_q`, `timer` and `cnt`.
- Edge detect:
  - `det_q` registers `det_in` every cycle regardless of state.
  - `evt = det_in & ~det_q`.
  - A high level lasting N cycles counts once.
  - Events are counted only in RUN.
- FSM states: IDLE, RUN.
  - IDLE -> RUN when en=1 and clr=0. Entering RUN sets `timer` and `cnt` to 0.
  - RUN -> IDLE when en=0. The partial window is discarded (`cnt` and `timer` set to 0). A pending `win_valid` is retained until accepted.
- RUN, per cycle:
  - `timer` increments.
  - `cnt` increments on `evt`, saturating at 2^CNT_W-1.
  - `total_count` increments on `evt`, saturating at 2^CNT_W-1.
- Window end: on the edge where `timer == WIN_LEN-1`:
  - `win_count` <= `cnt` + `evt` (saturated).
  - `cnt` <= 0 and `timer` <= 0.
  - `win_valid` <= 1.
  - An event in the last cycle belongs to the ending window.
- alert:
  - High for exactly one cycle, on the cycle after the event that makes the window count equal THRESH.
  - At most one alert per window.
  - No alert when THRESH is reached via saturation without equality; THRESH ≤ max count guarantees equality is hit.
- Handshake:
  - `win_valid` falls on the edge where `win_valid & win_ready`.
  - `win_count` is stable while `win_valid=1 & win_ready=0`, except on overwrite (below).
  - Window end in the same cycle as acceptance: new data loads, `win_valid` stays 1, `overrun` unchanged.
  - Window end while `win_valid=1 & win_ready=0`: new data overwrites `win_count`, `win_valid` stays 1, `overrun` <= 1.
  - `win_ready` is ignored when `win_valid=0`.
- clr (synchronous, highest priority after reset):
  - Zeroes `cnt`, `timer`, `total_count`, `win_count`, `win_valid`, `overrun` and `alert`.
  - FSM goes to IDLE; RUN can be re-entered on the next cycle if en=1.
  - `evt` in a clr cycle is dropped.
- Reset mid-window: everything returns to reset values immediately; no partial report is produced.
- Latency:
  - Event to `total_count`/`cnt` update: 1 cycle.
  - Last window cycle to `win_valid`: 1 cycle.

Test Plan:
- Basic window (WIN_LEN=16, THRESH=2, en=1): 1-cycle `det_in` pulses at window cycles 3, 7, 11 -> `win_valid=1` after cycle 15 with `win_count=3`; `alert` pulses once, the cycle after the cycle-7 event; `total_count=3`.
- Level filtering: `det_in` held high for 5 cycles, then 1-cycle pulses at cycles 10 and 12 -> window count 3, not 7.
- Saturation (CNT_W=2, THRESH=3): 5 separated pulses in one window -> `win_count=3`, `total_count=3`; single alert on the 3rd event.
- Overrun: `win_ready=0` across two window ends with counts 2 then 1 -> `win_count=1`, `overrun=1`. Then `win_ready=1` for one cycle -> `win_valid=0`, `overrun` stays 1 until clr.
- Boundary: event in the last window cycle, with `win_ready=1` held -> counted in the ending window; the next window starts from 0; back-to-back windows keep `win_valid` high with no overrun.
- Mid-operation: rst=0 at window cycle 8 with 2 counted events -> all outputs 0 at once. Separately, en=0 at cycle 8 -> IDLE, no report, `total_count` keeps 2; clr -> `total_count=0`.
